// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Bytes are accepted over a valid/ready handshake,
// queued in a small FIFO and sent LSB-first on uart_tx. Frames follow each
// other with no idle gap. The bit period is taken from clk_per_bit each time a
// frame starts and is held for the whole frame.
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN  adds an even-parity bit between the data bits and the
//                      stop bit, giving 8E1 frames of 11 bit periods. When the
//                      macro is undefined, frames are 8N1 with 10 bit periods.
//
// Parameters:
//   CLK_BITS    width of clk_per_bit and of the bit-period counter
//   FIFO_DEPTH  FIFO entries; must be a power of 2 and at least 2
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous reset, active-high
//   clk_per_bit  clock cycles per UART bit, sampled at frame start
//   tx_data      byte to enqueue
//   tx_valid     tx_data is valid
//   tx_ready     FIFO can accept a byte (not full)
//   uart_tx      registered serial line, idle high
//   busy         frame in flight or FIFO non-empty
//   fifo_count   current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_BITS   = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLK_BITS-1:0]           clk_per_bit,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [CLK_BITS-1:0] PER_ONE    = CLK_BITS'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Line level for a given state. data_bit carries the shift LSB in DATA and
  // the parity bit in PARITY.
  function automatic logic line_level(input logic [2:0] st, input logic data_bit);
    logic lvl;
    lvl = 1'b1;
    case (st)
      ST_START:  lvl = 1'b0;
      ST_DATA:   lvl = data_bit;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: lvl = data_bit;
`endif
      default:   lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // Control state (reset)
  logic [2:0]          state_q, state_d;
  logic [CLK_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                uart_tx_q, uart_tx_d;

  // Datapath state (no reset)
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          shift_q, shift_d;
  logic [CLK_BITS-1:0] period_q, period_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic can_start;
  logic bit_end;
  logic line_bit;

  always_comb begin
    full      = (count_q == FULL_COUNT);
    empty     = (count_q == '0);
    tx_ready  = !full;
    push      = tx_valid && !full;
    can_start = !empty && (clk_per_bit != '0);
    bit_end   = (cnt_q == period_q - PER_ONE);

    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    period_d  = period_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    pop       = 1'b0;

    // The bit counter free-runs from 0 to period-1 in every non-idle state;
    // each wrap marks the end of one bit.
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + PER_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting,
        // so consecutive frames have no idle cycles between them.
        if (bit_end) begin
          if (can_start) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: load the head byte and freeze the period for this frame.
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      period_d = clk_per_bit;
      cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // uart_tx is registered from the next state so the line changes on the
    // same edge as the state it belongs to.
`ifdef UART_TX_PARITY_EN
    line_bit = (state_d == ST_PARITY) ? parity_d : shift_d[0];
`else
    line_bit = shift_d[0];
`endif
    uart_tx_d = line_level(state_d, line_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
    shift_q  <= shift_d;
    period_q <= period_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign uart_tx    = uart_tx_q;
  assign busy       = (state_q != ST_IDLE) || !empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. Bytes pushed into the DUT are queued on a
// scoreboard; a line monitor decodes every frame on uart_tx using the bench's
// own notion of the bit period and pops the scoreboard to compare.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_BITS   = 10;
  localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic                         clk = 1'b0;
  logic                         rst;
  logic [CLK_BITS-1:0]          clk_per_bit;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         uart_tx;
  logic                         busy;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  uart_tx_fifo #(
    .CLK_BITS   (CLK_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_per_bit (clk_per_bit),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sb [$];
  int         starts_q [$];
  int         frames_seen = 0;
  int         last_start  = -1;
  int         p_cur       = 4;
  logic       mon_en      = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte, wait (bounded) for tx_ready, return the cycle number seen
  // right after the accepting edge. Ends on the following falling edge.
  task automatic push_byte(input logic [7:0] b, output int acc);
    int w;
    w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("push_ready_timeout", tx_ready, 1);
    if (tx_ready === 1'b1) sb.push_back(b);
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    fall = cyc;
  endtask

  // Line monitor: sample every cycle on the falling edge, insist each bit is
  // flat for p_cur cycles, and compare the decoded byte to the scoreboard.
  logic [FRAME_BITS-1:0] m_bits;
  logic                  m_stable;
  int                    m_p;
  logic [7:0]            m_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        m_p      = p_cur;
        m_stable = 1'b1;
        last_start = cyc;
        starts_q.push_back(cyc);
        for (int j = 0; j < FRAME_BITS; j++) begin
          for (int c = 0; c < m_p; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (c == 0) m_bits[j] = uart_tx;
            else if (uart_tx !== m_bits[j]) m_stable = 1'b0;
          end
        end
        check("frame_stable", m_stable, 1);
        check("start_bit", m_bits[0], 0);
        check("stop_bit", m_bits[FRAME_BITS-1], 1);
        m_exp = 8'hxx;
        if (sb.size() != 0) m_exp = sb.pop_front();
        check("rx_byte", m_bits[8:1], m_exp);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", m_bits[9], ^m_exp);
`endif
        frames_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc0, fall, bad, set_cyc, f0;

    rst         = 1'b1;
    clk_per_bit = 4;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;

    // Reset, then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 0) bad++;
    end
    check("idle_hold", bad, 0);

    // Single byte, P=4
    p_cur = 4;
    clk_per_bit = 4;
    f0 = frames_seen;
    push_byte(8'hA5, acc);
    wait_idle(200, fall);
    check("single_start_latency", last_start, acc + 1);
    check("single_busy_fall", fall, acc + 1 + FRAME_BITS * 4);
    check("single_frames", frames_seen - f0, 1);

    // Back-to-back until full, P=2
    p_cur = 2;
    clk_per_bit = 2;
    starts_q.delete();
    f0 = frames_seen;
    push_byte(8'h00, acc0);
    for (int i = 1; i < 9; i++) push_byte(8'(i), acc);
    check("b2b_push_cycles", acc - acc0, 8);
    check("b2b_full_count", fifo_count, 8);
    check("b2b_full_ready", tx_ready, 0);
    wait_idle(600, fall);
    check("b2b_frames", frames_seen - f0, 9);
    bad = 0;
    for (int i = 1; i < starts_q.size(); i++)
      if (starts_q[i] - starts_q[i-1] != FRAME_BITS * 2) bad++;
    check("b2b_gaps", bad, 0);
    check("b2b_total_time", fall, acc0 + 1 + 9 * FRAME_BITS * 2);

    // One-cycle bits
    p_cur = 1;
    clk_per_bit = 1;
    push_byte(8'h5A, acc);
    wait_idle(100, fall);
    check("p1_start_latency", last_start, acc + 1);
    check("p1_busy_fall", fall, acc + 1 + FRAME_BITS);

    // Zero period holds the FIFO
    clk_per_bit = 0;
    push_byte(8'h3C, acc);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    check("zero_line_high", bad, 0);
    check("zero_fifo_count", fifo_count, 1);
    check("zero_busy", busy, 1);
    p_cur = 8;
    clk_per_bit = 8;
    set_cyc = cyc;
    wait_idle(200, fall);
    check("zero_release_start", last_start, set_cyc + 1);
    check("zero_busy_fall", fall, set_cyc + 1 + FRAME_BITS * 8);

`ifdef UART_TX_PARITY_EN
    // Parity frames, P=4
    p_cur = 4;
    clk_per_bit = 4;
    push_byte(8'h07, acc);
    wait_idle(200, fall);
    check("par07_busy_fall", fall, acc + 1 + 44);
    push_byte(8'h03, acc);
    wait_idle(200, fall);
    check("par03_busy_fall", fall, acc + 1 + 44);
`endif

    check("sb_drained", sb.size(), 0);

    // Mid-frame reset, P=8; a second byte is left queued behind the first
    mon_en = 1'b0;
    p_cur = 8;
    clk_per_bit = 8;
    push_byte(8'hFF, acc);
    push_byte(8'h00, acc);
    repeat (36) @(negedge clk);
    check("mid_busy_before", busy, 1);
    check("mid_count_before", fifo_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_uart_tx", uart_tx, 1);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("mid_no_frame_after", bad, 0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
